// File: rtl/zero_run_monitor_pkg.sv
// Shared definitions for the zero-run monitor: FSM state encodings and default sizing,
// reused by the bench and by the zero detector's top level.
package zero_run_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    ALARM = 2'b10
  } mon_state_e;

  localparam int CNT_W_DEF     = 8;
  localparam int ALARM_LEN_DEF = 4;

endpackage

// File: rtl/zero_run_monitor_sat_counter.sv
// W-bit incrementer that sticks at all-ones; a synchronous clear takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock_i,
  input  logic         reset_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/zero_run_monitor.sv
// Measures runs of consecutive high y, tracks longest/number of completed runs, and
// raises a latched alarm when a run reaches ALARM_LEN, held until acknowledged.
module zero_run_monitor
  import zero_run_monitor_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int ALARM_LEN = ALARM_LEN_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             y,
  input  logic             clear,
  input  logic             ack,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] max_run,
  output logic [CNT_W-1:0] run_count,
  output logic             alarm,
  output logic [1:0]       mon_state
);

  // Run length one short of the trigger: the alarm fires on the edge that makes it ALARM_LEN.
  localparam logic [CNT_W-1:0] ALARM_CMP = CNT_W'(ALARM_LEN - 1);

  logic [CNT_W-1:0] run_len_s;
  logic [CNT_W-1:0] run_count_s;
  logic [CNT_W-1:0] max_run_q;
  logic [CNT_W-1:0] max_run_d;
  logic             run_end_s;
  logic             alarm_s;
  mon_state_e       state_q;
  mon_state_e       state_d;

  assign run_end_s = !y && (run_len_s != '0);

  sat_counter #(.W(CNT_W)) u_run_len (
    .clock_i  (clock),
    .reset_ni (reset),
    .clr_i    (!y),
    .inc_i    (y),
    .count_o  (run_len_s)
  );

  sat_counter #(.W(CNT_W)) u_run_count (
    .clock_i  (clock),
    .reset_ni (reset),
    .clr_i    (clear),
    .inc_i    (run_end_s),
    .count_o  (run_count_s)
  );

  // Longest completed run; clear wins over a coincident run end.
  always_comb begin
    max_run_d = max_run_q;
    if (clear) begin
      max_run_d = '0;
    end else if (run_end_s && (run_len_s > max_run_q)) begin
      max_run_d = run_len_s;
    end else begin
      max_run_d = max_run_q;
    end
  end

  // Statistics and state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      max_run_q <= '0;
      state_q   <= IDLE;
    end else begin
      max_run_q <= max_run_d;
      state_q   <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (y) begin
          state_d = (ALARM_LEN == 1) ? ALARM : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!y) begin
          state_d = IDLE;
        end else if (run_len_s == ALARM_CMP) begin
          state_d = ALARM;
        end else begin
          state_d = RUN;
        end
      end
      ALARM: begin
        if (ack) begin
          state_d = y ? RUN : IDLE;
        end else begin
          state_d = ALARM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the state register only.
  always_comb begin
    alarm_s = 1'b0;
    if (state_q == ALARM) begin
      alarm_s = 1'b1;
    end else begin
      alarm_s = 1'b0;
    end
  end

  assign run_len   = run_len_s;
  assign max_run   = max_run_q;
  assign run_count = run_count_s;
  assign alarm     = alarm_s;
  assign mon_state = state_q;

endmodule

// File: tb/tb_zero_run_monitor.sv
// Directed bench: table of per-cycle vectors for the default instance, plus hand sequences
// for saturation (4-bit instance) and asynchronous reset mid-alarm.
module tb_zero_run_monitor;
  import zero_run_monitor_pkg::*;

  typedef struct {
    logic       y;
    logic       clr;
    logic       ack;
    logic [7:0] rl;
    logic [7:0] mx;
    logic [7:0] cnt;
    logic       al;
    logic [1:0] st;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       y     = 1'b0;
  logic       y4    = 1'b0;
  logic       clear = 1'b0;
  logic       ack   = 1'b0;
  logic [7:0] run_len, max_run, run_count;
  logic       alarm;
  logic [1:0] mon_state;
  logic [3:0] run_len4, max_run4, run_count4;
  logic       alarm4;
  logic [1:0] mon_state4;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  always #5 clock = ~clock;

  zero_run_monitor #(.CNT_W(8), .ALARM_LEN(4)) dut (
    .clock(clock), .reset(reset), .y(y), .clear(clear), .ack(ack),
    .run_len(run_len), .max_run(max_run), .run_count(run_count),
    .alarm(alarm), .mon_state(mon_state)
  );

  zero_run_monitor #(.CNT_W(4), .ALARM_LEN(4)) dut4 (
    .clock(clock), .reset(reset), .y(y4), .clear(clear), .ack(ack),
    .run_len(run_len4), .max_run(max_run4), .run_count(run_count4),
    .alarm(alarm4), .mon_state(mon_state4)
  );

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic yv, input logic c, input logic a, input int rl,
                     input int mx, input int cnt, input logic al, input logic [1:0] st);
    vec_t v;
    v.y = yv; v.clr = c; v.ack = a;
    v.rl = 8'(rl); v.mx = 8'(mx); v.cnt = 8'(cnt);
    v.al = al; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic check_all8(input string nm, input int rl, input int mx, input int cnt,
                            input int al, input int st);
    check({nm, "_run_len"}, int'(run_len), rl);
    check({nm, "_max_run"}, int'(max_run), mx);
    check({nm, "_run_count"}, int'(run_count), cnt);
    check({nm, "_alarm"}, int'(alarm), al);
    check({nm, "_state"}, int'(mon_state), st);
  endtask

  initial begin
    // Run without alarm
    for (int k = 1; k <= 3; k++) add(1'b1, 1'b0, 1'b0, k, 0, 0, 1'b0, RUN);
    add(1'b0, 1'b0, 1'b0, 0, 3, 1, 1'b0, IDLE);
    // Alarm, run end while alarmed, then ack with y low
    for (int k = 1; k <= 3; k++) add(1'b1, 1'b0, 1'b0, k, 3, 1, 1'b0, RUN);
    for (int k = 4; k <= 6; k++) add(1'b1, 1'b0, 1'b0, k, 3, 1, 1'b1, ALARM);
    add(1'b0, 1'b0, 1'b0, 0, 6, 2, 1'b1, ALARM);
    add(1'b0, 1'b0, 1'b1, 0, 6, 2, 1'b0, IDLE);
    // Ack mid-run, no re-alarm
    for (int k = 1; k <= 3; k++) add(1'b1, 1'b0, 1'b0, k, 6, 2, 1'b0, RUN);
    for (int k = 4; k <= 5; k++) add(1'b1, 1'b0, 1'b0, k, 6, 2, 1'b1, ALARM);
    add(1'b1, 1'b0, 1'b1, 6, 6, 2, 1'b0, RUN);
    for (int k = 7; k <= 10; k++) add(1'b1, 1'b0, 1'b0, k, 6, 2, 1'b0, RUN);
    add(1'b0, 1'b0, 1'b0, 0, 10, 3, 1'b0, IDLE);
    // Ack in IDLE ignored, clear mid-run, clear colliding with run end of length 7
    add(1'b1, 1'b0, 1'b1, 1, 10, 3, 1'b0, RUN);
    add(1'b1, 1'b1, 1'b0, 2, 0, 0, 1'b0, RUN);
    add(1'b1, 1'b0, 1'b0, 3, 0, 0, 1'b0, RUN);
    for (int k = 4; k <= 7; k++) add(1'b1, 1'b0, 1'b0, k, 0, 0, 1'b1, ALARM);
    add(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b1, ALARM);
    add(1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0, IDLE);

    // Reset state
    #12;
    check_all8("reset", 0, 0, 0, 0, 0);
    check("reset_dut4_run_len", int'(run_len4), 0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      y = vecs[i].y; clear = vecs[i].clr; ack = vecs[i].ack;
      @(posedge clock);
      #1;
      check_all8($sformatf("v%0d", i), int'(vecs[i].rl), int'(vecs[i].mx),
                 int'(vecs[i].cnt), int'(vecs[i].al), int'(vecs[i].st));
    end
    @(negedge clock);
    y = 1'b0; clear = 1'b0; ack = 1'b0;

    // Saturation on the 4-bit instance
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      y4 = 1'b1;
      @(posedge clock);
      #1;
      check($sformatf("sat%0d_run_len", k), int'(run_len4), (k > 15) ? 15 : k);
      check($sformatf("sat%0d_alarm", k), int'(alarm4), (k >= 4) ? 1 : 0);
    end
    @(negedge clock);
    y4 = 1'b0;
    @(posedge clock);
    #1;
    check("sat_end_run_len", int'(run_len4), 0);
    check("sat_end_max_run", int'(max_run4), 15);
    check("sat_end_run_count", int'(run_count4), 1);
    check("sat_end_alarm", int'(alarm4), 1);

    // Reset asserted in ALARM with run_len 9, no clock edge involved
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      y = 1'b1;
      @(posedge clock);
      #1;
      check($sformatf("pre_rst%0d_run_len", k), int'(run_len), k);
    end
    check("pre_rst_alarm", int'(alarm), 1);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_all8("async_rst", 0, 0, 0, 0, 0);
    check("async_rst_dut4_max_run", int'(max_run4), 0);
    check("async_rst_dut4_alarm", int'(alarm4), 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_all8("post_rst1", 1, 0, 0, 0, 1);
    @(negedge clock);
    y = 1'b0;
    @(posedge clock);
    #1;
    check_all8("post_rst2", 0, 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
